// File: rtl/pc_enable_unit.sv
// PC register, enable and next-PC select with six compare modes, stall hold,
// branch-taken pulse and sticky misalignment trap. PC_PERF_EN adds saturating counters.
module pc_enable_unit #(
    parameter int          WIDTH     = 32,
    parameter logic [63:0] RESET_VEC = 64'h0,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             PCWrite,
    input  logic             Branch,
    input  logic [2:0]       BranchMode,
    input  logic             Zero,
    input  logic             Sign,
    input  logic             Stall,
    input  logic [1:0]       PCSrc,
    input  logic [WIDTH-1:0] ALUResult,
    input  logic [WIDTH-1:0] ALUOut,
    input  logic [25:0]      JumpField,
    output logic [WIDTH-1:0] PC,
    output logic             PCEn,
    output logic             BranchTaken,
    output logic             MisalignErr
`ifdef PC_PERF_EN
    ,
    output logic [CNT_W-1:0] UpdateCount,
    output logic [CNT_W-1:0] TakenCount,
    output logic [CNT_W-1:0] StallCount
`endif
);

    localparam logic [WIDTH-1:0] RST_PC = RESET_VEC[WIDTH-1:0];

    logic             cond;
    logic [WIDTH-1:0] next_pc;
    logic             misaligned;
    logic             load;
    logic             taken_d;

    always_comb begin
        cond = 1'b0;
        case (BranchMode)
            3'b000:  cond = Zero;
            3'b001:  cond = ~Zero;
            3'b010:  cond = Sign | Zero;
            3'b011:  cond = ~Sign & ~Zero;
            3'b100:  cond = Sign;
            3'b101:  cond = ~Sign;
            default: cond = 1'b0;
        endcase
    end

    // Jump target keeps the current upper PC bits; they never carry.
    always_comb begin
        next_pc = PC;
        case (PCSrc)
            2'b00:   next_pc = ALUResult;
            2'b01:   next_pc = ALUOut;
            2'b10:   next_pc = {PC[WIDTH-1:28], JumpField, 2'b00};
            default: next_pc = PC;
        endcase
    end

    assign PCEn       = (PCWrite | (Branch & cond)) & ~Stall & ~MisalignErr;
    assign misaligned = next_pc[1:0] != 2'b00;
    assign load       = PCEn & ~misaligned;
    assign taken_d    = Branch & cond & ~Stall & ~MisalignErr & ~PCWrite;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PC          <= RST_PC;
            BranchTaken <= 1'b0;
            MisalignErr <= 1'b0;
        end else begin
            BranchTaken <= taken_d;
            if (load)
                PC <= next_pc;
            // A misaligned target traps and freezes the PC until reset.
            if (PCEn && misaligned)
                MisalignErr <= 1'b1;
        end
    end

`ifdef PC_PERF_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            UpdateCount <= '0;
            TakenCount  <= '0;
            StallCount  <= '0;
        end else begin
            if (load && UpdateCount != CNT_MAX)
                UpdateCount <= UpdateCount + CNT_W'(1);
            if (taken_d && TakenCount != CNT_MAX)
                TakenCount <= TakenCount + CNT_W'(1);
            if (Stall && (PCWrite || Branch) && StallCount != CNT_MAX)
                StallCount <= StallCount + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pc_enable_unit.sv
// Table-driven bench for pc_enable_unit: PCEn checked combinationally,
// registered results go through a scoreboard queue checked after each edge.
module tb_pc_enable_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        PCWrite, Branch, Zero, Sign, Stall;
    logic [2:0]  BranchMode;
    logic [1:0]  PCSrc;
    logic [31:0] ALUResult, ALUOut;
    logic [25:0] JumpField;
    logic [31:0] PC;
    logic        PCEn, BranchTaken, MisalignErr;
`ifdef PC_PERF_EN
    logic [15:0] UpdateCount, TakenCount, StallCount;
`endif

    pc_enable_unit #(.WIDTH(32), .RESET_VEC(64'h0), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .PCWrite(PCWrite), .Branch(Branch),
        .BranchMode(BranchMode), .Zero(Zero), .Sign(Sign), .Stall(Stall),
        .PCSrc(PCSrc), .ALUResult(ALUResult), .ALUOut(ALUOut),
        .JumpField(JumpField), .PC(PC), .PCEn(PCEn),
        .BranchTaken(BranchTaken), .MisalignErr(MisalignErr)
`ifdef PC_PERF_EN
        , .UpdateCount(UpdateCount), .TakenCount(TakenCount), .StallCount(StallCount)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pcw, br;
        logic [2:0]  mode;
        logic        z, s, st;
        logic [1:0]  src;
        logic [31:0] alur, aluo;
        logic [25:0] jf;
        logic        e_pcen;
        logic [31:0] e_pc;
        logic        e_bt, e_err;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] pc;
        logic        bt, err;
    } exp_t;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];
    vec_t tbl[30];

    function automatic vec_t mk(input logic pcw, input logic br, input logic [2:0] mode,
                                input logic z, input logic s, input logic st,
                                input logic [1:0] src, input logic [31:0] alur,
                                input logic [31:0] aluo, input logic [25:0] jf,
                                input logic e_pcen, input logic [31:0] e_pc,
                                input logic e_bt, input logic e_err);
        vec_t v;
        v.pcw = pcw; v.br = br; v.mode = mode; v.z = z; v.s = s; v.st = st;
        v.src = src; v.alur = alur; v.aluo = aluo; v.jf = jf;
        v.e_pcen = e_pcen; v.e_pc = e_pc; v.e_bt = e_bt; v.e_err = e_err;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        PCWrite = 0; Branch = 0; BranchMode = 0; Zero = 0; Sign = 0; Stall = 0;
        PCSrc = 0; ALUResult = 0; ALUOut = 0; JumpField = 0;
    endtask

    task automatic apply(input int idx, input vec_t v);
        exp_t e;
        @(negedge clk);
        PCWrite = v.pcw; Branch = v.br; BranchMode = v.mode; Zero = v.z; Sign = v.s;
        Stall = v.st; PCSrc = v.src; ALUResult = v.alur; ALUOut = v.aluo; JumpField = v.jf;
        #1;
        check($sformatf("v%0d PCEn", idx), {31'b0, PCEn}, {31'b0, v.e_pcen});
        e.idx = idx; e.pc = v.e_pc; e.bt = v.e_bt; e.err = v.e_err;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL v%0d scoreboard: queue empty", idx);
        end else begin
            e = sb.pop_front();
            check($sformatf("v%0d PC", e.idx), PC, e.pc);
            check($sformatf("v%0d BranchTaken", e.idx), {31'b0, BranchTaken}, {31'b0, e.bt});
            check($sformatf("v%0d MisalignErr", e.idx), {31'b0, MisalignErr}, {31'b0, e.err});
        end
    endtask

    initial begin
        //             pcw br mode  z  s  st src   alur          aluo          jf           pcen pc            bt err
        tbl[0]  = mk(1, 0, 3'd0, 0, 0, 0, 2'd0, 32'h4,        32'h0,        26'h0,       1, 32'h4,        0, 0);
        tbl[1]  = mk(0, 0, 3'd0, 0, 0, 0, 2'd0, 32'h0,        32'h0,        26'h0,       0, 32'h4,        0, 0);
        tbl[2]  = mk(0, 1, 3'd0, 1, 0, 0, 2'd1, 32'h0,        32'h100,      26'h0,       1, 32'h100,      1, 0);
        tbl[3]  = mk(0, 1, 3'd0, 0, 0, 0, 2'd1, 32'h0,        32'h104,      26'h0,       0, 32'h100,      0, 0);
        tbl[4]  = mk(0, 1, 3'd1, 0, 0, 0, 2'd1, 32'h0,        32'h108,      26'h0,       1, 32'h108,      1, 0);
        tbl[5]  = mk(0, 1, 3'd1, 1, 0, 0, 2'd1, 32'h0,        32'h10C,      26'h0,       0, 32'h108,      0, 0);
        tbl[6]  = mk(0, 1, 3'd2, 0, 1, 0, 2'd1, 32'h0,        32'h110,      26'h0,       1, 32'h110,      1, 0);
        tbl[7]  = mk(0, 1, 3'd2, 1, 0, 0, 2'd1, 32'h0,        32'h114,      26'h0,       1, 32'h114,      1, 0);
        tbl[8]  = mk(0, 1, 3'd2, 0, 0, 0, 2'd1, 32'h0,        32'h118,      26'h0,       0, 32'h114,      0, 0);
        tbl[9]  = mk(0, 1, 3'd3, 0, 0, 0, 2'd1, 32'h0,        32'h11C,      26'h0,       1, 32'h11C,      1, 0);
        tbl[10] = mk(0, 1, 3'd3, 0, 1, 0, 2'd1, 32'h0,        32'h120,      26'h0,       0, 32'h11C,      0, 0);
        tbl[11] = mk(0, 1, 3'd3, 1, 0, 0, 2'd1, 32'h0,        32'h124,      26'h0,       0, 32'h11C,      0, 0);
        tbl[12] = mk(0, 1, 3'd4, 0, 1, 0, 2'd1, 32'h0,        32'h128,      26'h0,       1, 32'h128,      1, 0);
        tbl[13] = mk(0, 1, 3'd4, 0, 0, 0, 2'd1, 32'h0,        32'h12C,      26'h0,       0, 32'h128,      0, 0);
        tbl[14] = mk(0, 1, 3'd5, 0, 0, 0, 2'd1, 32'h0,        32'h130,      26'h0,       1, 32'h130,      1, 0);
        tbl[15] = mk(0, 1, 3'd5, 0, 1, 0, 2'd1, 32'h0,        32'h134,      26'h0,       0, 32'h130,      0, 0);
        tbl[16] = mk(0, 1, 3'd6, 1, 0, 0, 2'd1, 32'h0,        32'h138,      26'h0,       0, 32'h130,      0, 0);
        tbl[17] = mk(0, 1, 3'd7, 1, 1, 0, 2'd1, 32'h0,        32'h13C,      26'h0,       0, 32'h130,      0, 0);
        tbl[18] = mk(0, 1, 3'd7, 0, 0, 0, 2'd1, 32'h0,        32'h140,      26'h0,       0, 32'h130,      0, 0);
        tbl[19] = mk(1, 1, 3'd0, 1, 0, 0, 2'd0, 32'h200,      32'h300,      26'h0,       1, 32'h200,      0, 0);
        tbl[20] = mk(1, 0, 3'd0, 0, 0, 1, 2'd0, 32'h8,        32'h0,        26'h0,       0, 32'h200,      0, 0);
        tbl[21] = mk(0, 1, 3'd0, 1, 0, 1, 2'd1, 32'h0,        32'h400,      26'h0,       0, 32'h200,      0, 0);
        tbl[22] = mk(1, 0, 3'd0, 0, 0, 0, 2'd3, 32'h4,        32'h8,        26'h0,       1, 32'h200,      0, 0);
        tbl[23] = mk(1, 0, 3'd0, 0, 0, 0, 2'd0, 32'h40000010, 32'h0,        26'h0,       1, 32'h40000010, 0, 0);
        tbl[24] = mk(1, 0, 3'd0, 0, 0, 0, 2'd2, 32'h0,        32'h0,        26'h40,      1, 32'h40000100, 0, 0);
        tbl[25] = mk(0, 1, 3'd0, 1, 0, 0, 2'd2, 32'h0,        32'h0,        26'h3FFFFFF, 1, 32'h4FFFFFFC, 1, 0);
        tbl[26] = mk(0, 0, 3'd0, 0, 0, 0, 2'd0, 32'h0,        32'h0,        26'h0,       0, 32'h4FFFFFFC, 0, 0);
        tbl[27] = mk(1, 0, 3'd0, 0, 0, 0, 2'd0, 32'h6,        32'h0,        26'h0,       1, 32'h4FFFFFFC, 0, 1);
        tbl[28] = mk(1, 0, 3'd0, 0, 0, 0, 2'd0, 32'h8,        32'h0,        26'h0,       0, 32'h4FFFFFFC, 0, 1);
        tbl[29] = mk(0, 1, 3'd0, 1, 0, 0, 2'd1, 32'h0,        32'h500,      26'h0,       0, 32'h4FFFFFFC, 0, 1);

        drive_idle();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("reset PC", PC, 32'h0);
        check("reset PCEn", {31'b0, PCEn}, 32'h0);
        check("reset BranchTaken", {31'b0, BranchTaken}, 32'h0);
        check("reset MisalignErr", {31'b0, MisalignErr}, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 30; i++)
            apply(i, tbl[i]);

`ifdef PC_PERF_EN
        check("UpdateCount", {16'b0, UpdateCount}, 32'd13);
        check("TakenCount", {16'b0, TakenCount}, 32'd8);
        check("StallCount", {16'b0, StallCount}, 32'd2);
`endif

        // Mid-cycle asynchronous reset clears the trap and reloads the vector.
        @(negedge clk);
        PCWrite = 1; PCSrc = 2'd0; ALUResult = 32'h8;
        #2;
        reset = 1'b1;
        #1;
        check("async reset PC", PC, 32'h0);
        check("async reset MisalignErr", {31'b0, MisalignErr}, 32'h0);
        check("async reset BranchTaken", {31'b0, BranchTaken}, 32'h0);
`ifdef PC_PERF_EN
        check("async reset UpdateCount", {16'b0, UpdateCount}, 32'd0);
`endif
        @(posedge clk);
        #1;
        check("held in reset PC", PC, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post reset PCEn", {31'b0, PCEn}, 32'h1);
        @(posedge clk);
        #1;
        check("first update after reset PC", PC, 32'h8);
        drive_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pc_enable_unit.md
Name: pc_enable_unit

Overview:
- Parametrised successor to the multicycle PC-enable logic.
- Owns the PC register and its enable.
- Generalises the branch condition from BEQ-only to six MIPS compare modes. Adds stall hold, next-PC source selection, a registered branch-taken flag and a sticky misalignment trap.
- Sits between the control FSM / ALU and the instruction-fetch address path.

Parameters:
- WIDTH, 32, PC/datapath width; legal range 29..64.
- RESET_VEC, 32'h0000_0000, PC value loaded on reset (low WIDTH bits used); low 2 bits must be 0.
- CNT_W, 16, width of the optional performance counters.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- PCWrite  in  1  unconditional PC update request from control FSM.
- Branch  in  1  conditional PC update request.
- BranchMode  in  3  condition select: 000 BEQ, 001 BNE, 010 BLEZ, 011 BGTZ, 100 BLTZ, 101 BGEZ, 110/111 never.
- Zero  in  1  ALU zero flag.
- Sign  in  1  ALU result MSB.
- Stall  in  1  hold PC and suppress enable.
- PCSrc  in  2  next-PC source: 00 ALUResult, 01 ALUOut, 10 jump target, 11 hold (current PC).
- ALUResult  in  WIDTH  PC+4 from ALU.
- ALUOut  in  WIDTH  registered branch target.
- JumpField  in  26  instr[25:0].
- PC  out  WIDTH  current program counter.
- PCEn  out  1  combinational enable.
- BranchTaken  out  1  registered one-cycle pulse.
- MisalignErr  out  1  sticky trap flag.

Behaviour:
- Condition (cond):
  - BEQ = Zero; BNE = ~Zero.
  - BLEZ = Sign | Zero; BGTZ = ~Sign & ~Zero.
  - BLTZ = Sign; BGEZ = ~Sign.
  - 110/111 = 0.
- PCEn = (PCWrite | (Branch & cond)) & ~Stall & ~MisalignErr. Combinational, zero latency.
- NextPC, by PCSrc:
  - 00 = ALUResult.
  - 01 = ALUOut.
  - 10 = {PC[WIDTH-1:28], JumpField, 2'b00}.
  - 11 = PC.
- Misaligned: NextPC[1:0] != 0.
- On rising clk with PCEn=1:
  - Not misaligned: PC <= NextPC.
  - Misaligned: PC holds; MisalignErr <= 1.
- MisalignErr is sticky. Once set, PCEn is forced to 0 and PC is frozen. Only reset clears it.
- BranchTaken <= Branch & cond & ~Stall & ~MisalignErr & ~PCWrite, each cycle.
  - Goes high the cycle after a taken branch; lasts 1 cycle per taken request.
  - Low when PCWrite and Branch are asserted together: PCWrite wins, the update counts as unconditional, and the PCSrc selection still applies.
- Simultaneous Stall with any request: Stall wins. No PC update, no BranchTaken, no error capture.
- PCSrc=11 with PCEn=1: PC reloads its own value. This counts as an update for the counters.
- Reset (any time, including mid-update): PC=RESET_VEC[WIDTH-1:0], BranchTaken=0, MisalignErr=0, counters=0. Asynchronous assertion; first update on the first rising edge after deassertion.
- Jump-target wrap: upper PC bits come from the current PC and are never incremented.
- Unknown BranchMode values never assert cond.

Optional Feature:
- Macro PC_PERF_EN.
- Defined:
  - Adds outputs UpdateCount[CNT_W] (increments on each cycle with an actual PC load).
  - Adds TakenCount[CNT_W] (increments with each BranchTaken pulse).
  - Adds StallCount[CNT_W] (increments each cycle Stall=1 and a request is pending).
  - All saturate at all-ones and never wrap; all reset to 0.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset with reset=1, then release -> PC=0x00000000, PCEn=0, BranchTaken=0, MisalignErr=0.
- PCWrite=1, PCSrc=00, ALUResult=0x4 -> PCEn=1 same cycle; PC=0x4 next edge; BranchTaken stays 0.
- Branch=1, Sign/Zero sweep across all 8 BranchMode codes, ALUOut=0x100, PCSrc=01 -> PC loads 0x100 only where the condition table is true.
  - Checks: BEQ Z=1, BNE Z=0, BLEZ S=1, BGTZ S=0 Z=0, BLTZ S=1, BGEZ S=0.
  - BranchTaken pulses 1 cycle later; codes 110/111 never load.
- Stall=1 with PCWrite=1, ALUResult=0x8 -> PCEn=0, PC unchanged. With PC_PERF_EN: StallCount +1, UpdateCount unchanged.
- PC=0x40000010, PCSrc=10, JumpField=0x0000040, PCWrite=1 -> PC=0x40000100.
- PCWrite=1, ALUResult=0x6 -> PC held, MisalignErr=1.
  - Later PCWrite with ALUResult=0x8 -> still held, PCEn=0.
  - Assert reset mid-cycle -> PC=RESET_VEC immediately, MisalignErr=0.
